// File: rtl/complete_arbiter_if.sv
// rtl/complete_arbiter_if.sv - FU completion ports and CDB broadcast bundle for complete_arbiter
//
// Signals:
//   fu_valid   [NUM_FU]        FU i presents a finished result
//   fu_pkt     [NUM_FU*PKT_W]  payload of FU i in bits [i*PKT_W +: PKT_W]
//   fu_ready   [NUM_FU]        slot i accepts a result this cycle
//   cdb_valid                  registered broadcast valid
//   cdb_pkt    [PKT_W]         registered broadcast payload
//   cdb_fu     [CNT_W]         index of the FU that produced cdb_pkt
//   busy_count [CNT_W]         number of occupied slots
// Modports: master = FU cluster / CDB consumer side, slave = arbiter side.
interface complete_arbiter_if #(
    parameter int NUM_FU = 6,
    parameter int PKT_W  = 44,
    parameter int CNT_W  = 3
);
    logic [NUM_FU-1:0]       fu_valid;
    logic [NUM_FU*PKT_W-1:0] fu_pkt;
    logic [NUM_FU-1:0]       fu_ready;
    logic                    cdb_valid;
    logic [PKT_W-1:0]        cdb_pkt;
    logic [CNT_W-1:0]        cdb_fu;
    logic [CNT_W-1:0]        busy_count;

    modport master (
        output fu_valid,
        output fu_pkt,
        input  fu_ready,
        input  cdb_valid,
        input  cdb_pkt,
        input  cdb_fu,
        input  busy_count
    );

    modport slave (
        input  fu_valid,
        input  fu_pkt,
        output fu_ready,
        output cdb_valid,
        output cdb_pkt,
        output cdb_fu,
        output busy_count
    );
endinterface

// File: rtl/complete_arbiter.sv
// rtl/complete_arbiter.sv - per-FU completion slots with round-robin CDB broadcast
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high reset
//   flush  synchronous squash: empties all slots, kills the broadcast, rr_ptr to 0
//   bus    complete_arbiter_if.slave: fu_valid/fu_pkt/fu_ready handshake per FU,
//          registered cdb_valid/cdb_pkt/cdb_fu broadcast, busy_count popcount
module complete_arbiter #(
    parameter int NUM_FU = 6,
    parameter int PKT_W  = 44,
    parameter int CNT_W  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    complete_arbiter_if.slave     bus
);

    logic [NUM_FU-1:0] slot_valid;
    logic [PKT_W-1:0]  slot_pkt [NUM_FU];
    logic [CNT_W-1:0]  rr_ptr;

    logic              cdb_valid_q;
    logic [PKT_W-1:0]  cdb_pkt_q;
    logic [CNT_W-1:0]  cdb_fu_q;
    logic [CNT_W-1:0]  busy_count_q;

    logic [NUM_FU-1:0] grant;
    logic              grant_any;
    logic [CNT_W-1:0]  grant_idx;
    logic [CNT_W:0]    scan_idx;
    logic [NUM_FU-1:0] ready;
    logic [NUM_FU-1:0] xfer;
    logic [NUM_FU-1:0] slot_valid_nxt;
    logic [CNT_W-1:0]  busy_nxt;

    // Round-robin search starting at rr_ptr. scan_idx carries one extra bit so
    // rr_ptr + k never overflows before the modulo-NUM_FU fold.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = {1'b0, rr_ptr} + (CNT_W+1)'(k);
            if (scan_idx >= (CNT_W+1)'(NUM_FU)) begin
                scan_idx = scan_idx - (CNT_W+1)'(NUM_FU);
            end
            if (!grant_any && slot_valid[scan_idx[CNT_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[CNT_W-1:0];
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // A slot being drained this cycle is free to take a new result on the same edge.
    assign ready = {NUM_FU{~flush}} & (~slot_valid | grant);
    assign xfer  = bus.fu_valid & ready;

    // Refill wins over drain so a grant+refill leaves the slot full with the new packet.
    always_comb begin
        slot_valid_nxt = slot_valid;
        busy_nxt       = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (xfer[i]) begin
                slot_valid_nxt[i] = 1'b1;
            end else if (grant[i]) begin
                slot_valid_nxt[i] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            busy_nxt = busy_nxt + {{(CNT_W-1){1'b0}}, slot_valid_nxt[i]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_valid   <= '0;
            rr_ptr       <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_pkt_q    <= '0;
            cdb_fu_q     <= '0;
            busy_count_q <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                slot_pkt[i] <= '0;
            end
        end else if (flush) begin
            // Payloads and the last cdb_pkt/cdb_fu are left as-is; only validity matters.
            slot_valid   <= '0;
            rr_ptr       <= '0;
            cdb_valid_q  <= 1'b0;
            busy_count_q <= '0;
        end else begin
            slot_valid   <= slot_valid_nxt;
            busy_count_q <= busy_nxt;
            for (int i = 0; i < NUM_FU; i++) begin
                if (xfer[i]) begin
                    slot_pkt[i] <= bus.fu_pkt[i*PKT_W +: PKT_W];
                end
            end
            if (grant_any) begin
                cdb_valid_q <= 1'b1;
                cdb_pkt_q   <= slot_pkt[grant_idx];
                cdb_fu_q    <= grant_idx;
                rr_ptr      <= (grant_idx == CNT_W'(NUM_FU-1)) ? '0 : grant_idx + CNT_W'(1);
            end else begin
                cdb_valid_q <= 1'b0;
            end
        end
    end

    assign bus.fu_ready   = ready;
    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_pkt    = cdb_pkt_q;
    assign bus.cdb_fu     = cdb_fu_q;
    assign bus.busy_count = busy_count_q;

endmodule

// File: doc/complete_arbiter.md
Name: complete_arbiter

Overview:
- Complete-stage block directly downstream of the functional-unit cluster.
- Holds one finished result per FU in a private slot and picks one slot per cycle with a round-robin arbiter.
- Drives the winner onto a registered CDB broadcast (PRF write, RS wakeup, ROB complete).
- Returns a per-FU ready signal, so FUs stall instead of dropping results when several finish together.

Parameters:
- NUM_FU, 6, number of FU completion ports; index 0..NUM_FU-1.
- PKT_W, 44, completion payload width per FU (pr_idx, rob_idx, value, branch bits, packed by producer; opaque here).
- CNT_W, 3, width of busy_count; must satisfy 2^CNT_W > NUM_FU.

Ports:
- clock  in  1  Clock; all state updates on the rising edge.
- reset  in  1  Asynchronous reset, active-high.
- flush  in  1  Synchronous squash on branch mispredict.
- fu_valid  in  NUM_FU  FU i presents a finished result.
- fu_pkt  in  NUM_FU*PKT_W  Payload of FU i, in bits [i*PKT_W +: PKT_W].
- fu_ready  out  NUM_FU  Slot i can accept a result this cycle (combinational).
- cdb_valid  out  1  CDB broadcast valid (registered).
- cdb_pkt  out  PKT_W  Broadcast payload (registered).
- cdb_fu  out  CNT_W  Index of the FU that produced cdb_pkt (registered).
- busy_count  out  CNT_W  Number of occupied slots (registered state, popcount).

Behaviour:
- State:
  - slot_valid[NUM_FU] and slot_pkt[NUM_FU].
  - rr_ptr, CNT_W bits, range 0..NUM_FU-1.
  - Output registers cdb_valid, cdb_pkt, cdb_fu.
- Reset (asynchronous): slot_valid=0, slot_pkt=0, rr_ptr=0, cdb_valid=0, cdb_pkt=0, cdb_fu=0, busy_count=0. Because fu_ready is combinational, it reads all-ones while reset is held.
- Grant (combinational):
  - Choose the first i with slot_valid[i], searching rr_ptr, rr_ptr+1, … modulo NUM_FU.
  - At most one grant per cycle. No grant if no slot is valid.
- fu_ready[i] = !flush & (!slot_valid[i] | grant[i]). A slot being drained this cycle can be refilled on the same edge.
- Handshake:
  - A transfer occurs when fu_valid[i] & fu_ready[i] at a rising edge.
  - The FU must hold fu_valid and fu_pkt stable while fu_ready[i]=0.
- Each edge, when not flushing:
  - Granted slot g: cdb_valid<=1, cdb_pkt<=slot_pkt[g], cdb_fu<=g, rr_ptr<=(g==NUM_FU-1)?0:g+1.
  - No grant: cdb_valid<=0; cdb_pkt and cdb_fu hold; rr_ptr holds.
  - Slot i, in priority order:
    - If it transfers, slot_valid<=1 and slot_pkt<=fu_pkt.
    - Else if granted, slot_valid<=0.
    - Else it holds.
- Latency:
  - A result presented and accepted in cycle C occupies its slot in cycle C+1.
  - With no contention it appears on the CDB in cycle C+2.
  - The broadcast is valid for exactly one cycle per result.
- Throughput: one broadcast per cycle while any slot is occupied. No result is lost or duplicated.
- Fairness: a waiting slot is granted within NUM_FU cycles.
- Flush (synchronous, overrides all other updates): slot_valid<=0, cdb_valid<=0, rr_ptr<=0. fu_ready=0 during the flush cycle, so incoming results that cycle are dropped.
- busy_count equals the popcount of slot_valid after each edge. It reaches NUM_FU when all slots are full.
- Simultaneous events:
  - A grant and a refill of the same slot on the same edge leaves the slot full with the new packet.
  - Flush together with reset: reset wins.
  - Reset mid-broadcast clears cdb_valid immediately (asynchronous).

Test Plan:
- Single result: reset, then fu_valid[2]=1 with pkt=0xABC for 1 cycle -> cdb_valid=1, cdb_fu=2, cdb_pkt=0xABC exactly 2 cycles later for 1 cycle; busy_count 0→1→0.
- Burst: all 6 fu_valid high for 1 cycle with pkt=i, rr_ptr=0 -> cdb_fu sequence 0,1,2,3,4,5 on consecutive cycles; busy_count 6,5,4,3,2,1,0.
- Backpressure: slot 3 full and rr_ptr=4, FU3 keeps fu_valid high with a new pkt -> fu_ready[3]=0 until slot 3 is granted; on the grant cycle fu_ready[3]=1, the new pkt is accepted, and both packets broadcast in order.
- Wrap-around fairness: FU5 and FU0 both continuously valid -> cdb_fu alternates 5,0,5,0; neither waits more than 2 cycles.
- Flush: 4 slots full, flush=1 for 1 cycle -> next cycle cdb_valid=0, busy_count=0, fu_ready all 1; fu_valid in the flush cycle is never broadcast.
- Reset mid-operation: assert reset asynchronously while cdb_valid=1 and 3 slots full -> cdb_valid=0 and busy_count=0 immediately; after release, the single-result test passes again.
